pipeline_stall_controller: RTL

Central stall/flush scheduler for the 5-stage pipeline. It arbitrates every pipeline-hold source: the load-use signal from the hazard detection unit, data-memory wait handshakes, EX-stage taken branches and the HALT instruction. It drives one write-enable per pipeline register, plus the flush/bubble controls. It also sequences the HALT drain and the memory-timeout error state.

---
 rtl/pipeline_stall_controller_pkg.sv | 44 ++++
 rtl/pipeline_stall_controller_stall_priority_mux.sv | 49 ++++
 rtl/pipeline_stall_controller.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline definitions: FSM state encoding, stall/flush control vector,
// default timing parameters and the NOP word loaded by the flush paths.
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        ERROR  = 2'd3
    } state_e;

    localparam int DEF_DRAIN_CYCLES = 3;
    localparam int DEF_MEM_TIMEOUT  = 15;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_flush;
        logic exmem_write;
        logic memwb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN = '{
        pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_write: 1'b1,
        idex_flush: 1'b0, exmem_write: 1'b1, memwb_bubble: 1'b0
    };

    // Whole pipeline frozen, WB fed bubbles: memory wait, HALTED and ERROR.
    localparam ctrl_t CTRL_HOLD = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_write: 1'b0,
        idex_flush: 1'b0, exmem_write: 1'b0, memwb_bubble: 1'b1
    };

    localparam ctrl_t CTRL_RESET = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_write: 1'b0,
        idex_flush: 1'b1, exmem_write: 1'b0, memwb_bubble: 1'b1
    };

endpackage

// File: rtl/pipeline_stall_controller_stall_priority_mux.sv
// Combinational priority encoder: memory wait > taken branch > load-use > HALT,
// qualified by the controller state.
module pipeline_stall_controller_stall_priority_mux
    import pipeline_stall_controller_pkg::*;
(
    input  state_e state,
    input  logic   mw,
    input  logic   branch_taken,
    input  logic   lu_hazard,
    input  logic   halt,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = CTRL_RUN;
        case (state)
            RUN: begin
                if (mw) begin
                    ctrl = CTRL_HOLD;
                end else if (branch_taken) begin
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_flush = 1'b1;
                end else if (lu_hazard) begin
                    ctrl.pc_write   = 1'b0;
                    ctrl.ifid_write = 1'b0;
                    ctrl.idex_flush = 1'b1;
                end else if (halt) begin
                    // HALT itself advances into ID/EX; fetch stops behind it.
                    ctrl.pc_write   = 1'b0;
                    ctrl.ifid_write = 1'b0;
                end
            end
            DRAIN: begin
                if (mw) begin
                    ctrl = CTRL_HOLD;
                end else if (branch_taken) begin
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_flush = 1'b1;
                end else begin
                    ctrl.pc_write   = 1'b0;
                    ctrl.ifid_write = 1'b0;
                    ctrl.idex_flush = 1'b1;
                end
            end
            default: ctrl = CTRL_HOLD;
        endcase
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush scheduler: HALT drain sequencing, memory-wait timeout
// detection and stall-cycle accounting around the priority encoder.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lu_hazard,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        branch_taken,
    input  logic        halt,
    input  logic        resume,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_write,
    output logic        idex_flush,
    output logic        exmem_write,
    output logic        memwb_bubble,
    output logic [1:0]  state,
    output logic        mem_error,
    output logic [15:0] stall_cycles
);

    state_e      state_q, state_d;
    logic [7:0]  drain_q, drain_d;
    logic [7:0]  wait_q, wait_d;
    logic        err_q, err_d;
    logic [15:0] stall_q, stall_d;
    logic        mw;
    logic        active;
    logic        timeout;
    ctrl_t       ctrl;
    ctrl_t       out_ctrl;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign mw      = mem_req & ~mem_ready;
    assign active  = (state_q == RUN) || (state_q == DRAIN);
    // Error fires on the cycle the wait count would reach MEM_TIMEOUT.
    assign timeout = active && mw && (wait_q == 8'(MEM_TIMEOUT - 1));

    pipeline_stall_controller_stall_priority_mux u_prio (
        .state        (state_q),
        .mw           (mw),
        .branch_taken (branch_taken),
        .lu_hazard    (lu_hazard),
        .halt         (halt),
        .ctrl         (ctrl)
    );

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        wait_d  = 8'd0;
        err_d   = err_q;
        stall_d = stall_q;

        if (active) begin
            if (mw) wait_d = wait_q + 8'd1;
            if (!ctrl.pc_write) stall_d = sat_inc16(stall_q);
        end

        case (state_q)
            RUN: begin
                if (timeout) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end else if (!mw && !branch_taken && !lu_hazard && halt) begin
                    state_d = DRAIN;
                    drain_d = 8'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                if (timeout) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end else if (!mw) begin
                    if (branch_taken) begin
                        // HALT was on the wrong path; resume normal flow.
                        state_d = RUN;
                        drain_d = 8'd0;
                    end else begin
                        drain_d = (drain_q == 8'd0) ? 8'd0 : drain_q - 8'd1;
                        if (drain_q <= 8'd1) state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                if (resume) state_d = RUN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            drain_q <= 8'd0;
            wait_q  <= 8'd0;
            err_q   <= 1'b0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign out_ctrl     = rst ? CTRL_RESET : ctrl;
    assign pc_write     = out_ctrl.pc_write;
    assign ifid_write   = out_ctrl.ifid_write;
    assign ifid_flush   = out_ctrl.ifid_flush;
    assign idex_write   = out_ctrl.idex_write;
    assign idex_flush   = out_ctrl.idex_flush;
    assign exmem_write  = out_ctrl.exmem_write;
    assign memwb_bubble = out_ctrl.memwb_bubble;
    assign state        = state_q;
    assign mem_error    = err_q;
    assign stall_cycles = stall_q;

endmodule
